// File: rtl/sop_sweep_engine.sv
// Programmable sum-of-products / product-of-sums evaluator: minterm mask with
// single registered lookup and a handshaked full truth-table sweep that counts 1-rows.
module sop_sweep_engine #(
  parameter int unsigned N_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_clr,
  input  logic            cfg_we,
  input  logic [N_IN-1:0] cfg_idx,
  input  logic            cfg_val,
  input  logic            mode_pos,
  input  logic [N_IN-1:0] eval_in,
  output logic            eval_out,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] out_idx,
  output logic            out_bit,
  output logic            out_last,
  output logic [N_IN:0]   ones_cnt,
  output logic            done
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam int unsigned CW    = N_IN + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [DEPTH-1:0]  mask;
  logic              mode_q;
  logic [CW-1:0]     acc;
  logic [CW-1:0]     acc_nxt;
  logic [N_IN-1:0]   nxt_idx;
  logic              cfg_en;

  assign cfg_en  = (state != S_RUN);
  assign nxt_idx = out_idx + N_IN'(1);
  assign acc_nxt = acc + CW'(out_bit);

  // Mask storage: frozen while sweeping; a same-cycle clear is overridden by the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (cfg_en) begin
      if (cfg_clr) mask <= '0;
      if (cfg_we)  mask[cfg_idx] <= cfg_val;
    end
  end

  // Single lookup, live mode, sees the mask before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_out <= 1'b0;
    end else begin
      eval_out <= mode_pos ^ mask[eval_in];
    end
  end

  // Sweep controller; out_idx doubles as the row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      ones_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            mode_q    <= mode_pos;
            acc       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_bit   <= mode_pos ^ mask[0];
            out_last  <= 1'b0;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            acc <= acc_nxt;
            if (out_last) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_bit   <= 1'b0;
              out_last  <= 1'b0;
              ones_cnt  <= acc_nxt;
              done      <= 1'b1;
            end else begin
              out_idx  <= nxt_idx;
              out_bit  <= mode_q ^ mask[nxt_idx];
              out_last <= (nxt_idx == N_IN'(DEPTH - 1));
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sop_sweep_engine.sv
// Self-checking bench for sop_sweep_engine: N_IN=3 and N_IN=4 instances, reference
// mask model and a row scoreboard filled at sweep start and drained on each handshake.
module tb_sop_sweep_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] idx;
    logic       b;
    logic       last;
  } row_t;

  row_t q[$];

  // N_IN=3 instance
  logic       c_clr, c_we, c_val, mpos, start, rdy;
  logic [2:0] c_idx, ev_in, o_idx;
  logic       ev_out, busy, o_valid, o_bit, o_last, done;
  logic [3:0] ones;
  logic [7:0] m3;

  // N_IN=4 instance
  logic       d_clr, d_we, d_val, d_mpos, d_start, d_rdy;
  logic [3:0] d_idx, d_ev_in, d_oidx;
  logic       d_ev_out, d_busy, d_valid, d_bit, d_last, d_done;
  logic [4:0] d_ones;
  logic [15:0] m4;

  sop_sweep_engine #(.N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_clr(c_clr), .cfg_we(c_we), .cfg_idx(c_idx),
    .cfg_val(c_val), .mode_pos(mpos), .eval_in(ev_in), .eval_out(ev_out),
    .start(start), .busy(busy), .out_valid(o_valid), .out_ready(rdy),
    .out_idx(o_idx), .out_bit(o_bit), .out_last(o_last), .ones_cnt(ones), .done(done)
  );

  sop_sweep_engine #(.N_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_clr(d_clr), .cfg_we(d_we), .cfg_idx(d_idx),
    .cfg_val(d_val), .mode_pos(d_mpos), .eval_in(d_ev_in), .eval_out(d_ev_out),
    .start(d_start), .busy(d_busy), .out_valid(d_valid), .out_ready(d_rdy),
    .out_idx(d_oidx), .out_bit(d_bit), .out_last(d_last), .ones_cnt(d_ones), .done(d_done)
  );

  // Config write on the N_IN=3 instance; called at a negedge, returns at the next one.
  task automatic wr3(input logic clr, input logic we, input logic [2:0] idx, input logic val);
    c_clr = clr; c_we = we; c_idx = idx; c_val = val;
    @(negedge clk);
    c_clr = 1'b0; c_we = 1'b0;
    if (clr) m3 = '0;
    if (we)  m3[idx] = val;
  endtask

  task automatic load3(input logic [7:0] m);
    wr3(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) if (m[i]) wr3(1'b0, 1'b1, 3'(i), 1'b1);
  endtask

  // Full sweep on the N_IN=3 instance. bp: out_ready 0,1,0,1... ; inj: cfg_we and start during RUN.
  task automatic sweep3(input logic mp, input bit bp, input bit inj, input int exp_cyc, input int exp_ones);
    int   cyc;
    bit   fin;
    row_t r;
    row_t e;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      r.idx = 4'(i); r.b = mp ^ m3[i]; r.last = (i == 7);
      q.push_back(r);
    end
    mpos = mp; start = 1'b1; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0; mpos = ~mp;
    cyc = 0; fin = 1'b0;
    while (!fin && cyc <= 64) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        rdy   = bp ? ((cyc % 2) == 1) : 1'b1;
        c_we  = inj && (cyc == 2); c_idx = 3'd0; c_val = 1'b1;
        start = inj && (cyc == 2);
        e = (q.size() > 0) ? q[0] : '0;
        checks++;
        if (q.size() == 0 || o_valid !== 1'b1 || busy !== 1'b1 || o_idx !== e.idx[2:0] ||
            o_bit !== e.b || o_last !== e.last) begin
          errors++;
          $display("FAIL row cyc=%0d: got valid=%b busy=%b idx=%0d bit=%b last=%b, want idx=%0d bit=%b last=%b (pending %0d)",
                   cyc, o_valid, busy, o_idx, o_bit, o_last, e.idx, e.b, e.last, q.size());
        end else if (rdy) begin
          void'(q.pop_front());
        end
        @(negedge clk);
        cyc++;
      end
    end
    c_we = 1'b0; start = 1'b0; rdy = 1'b1; mpos = mp;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL sweep timeout: no done within %0d cycles", cyc);
    end else begin
      checks++;
      if (cyc != exp_cyc) begin
        errors++; $display("FAIL done latency: got %0d cycles, want %0d", cyc, exp_cyc);
      end
      checks++;
      if (ones !== 4'(exp_ones)) begin
        errors++; $display("FAIL ones_cnt: got %0d, want %0d", ones, exp_ones);
      end
      checks++;
      if (busy !== 1'b0 || o_valid !== 1'b0 || q.size() != 0) begin
        errors++; $display("FAIL done state: busy=%b valid=%b undelivered=%0d, want 0 0 0", busy, o_valid, q.size());
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ones !== 4'(exp_ones)) begin
        errors++; $display("FAIL done pulse/hold: done=%b ones=%0d, want 0 %0d", done, ones, exp_ones);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({ev_out, busy, o_valid, o_idx, o_bit, o_last, ones, done} !== '0 ||
        {d_ev_out, d_busy, d_valid, d_oidx, d_bit, d_last, d_ones, d_done} !== '0) begin
      errors++; $display("FAIL reset outputs: dut3 ones=%0d busy=%b, dut4 ones=%0d busy=%b, want all 0", ones, busy, d_ones, d_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_eval();
    logic mp;
    for (int i = 0; i < 8; i++) begin
      mp = 1'($urandom_range(0, 1));
      ev_in = 3'(i); mpos = mp;
      @(negedge clk);
      checks++;
      if (ev_out !== (mp ^ m3[i])) begin
        errors++; $display("FAIL eval idx=%0d pos=%b: got %b, want %b", i, mp, ev_out, mp ^ m3[i]);
      end
    end
    mpos = 1'b0;
  endtask

  task automatic test_write_timing();
    logic old_v;
    ev_in = 3'd4; mpos = 1'b0;
    @(negedge clk);
    old_v = m3[4];
    wr3(1'b0, 1'b1, 3'd4, ~old_v);
    checks++;
    if (ev_out !== old_v) begin
      errors++; $display("FAIL eval write edge: got %b, want old %b", ev_out, old_v);
    end
    @(negedge clk);
    checks++;
    if (ev_out !== ~old_v) begin
      errors++; $display("FAIL eval after write: got %b, want %b", ev_out, ~old_v);
    end
  endtask

  task automatic test_n4();
    int   cyc;
    row_t r;
    row_t e;
    int   lst[7] = '{1, 2, 3, 5, 7, 13, 15};
    d_clr = 1'b1; @(negedge clk); d_clr = 1'b0; m4 = '0;
    foreach (lst[i]) begin
      d_we = 1'b1; d_idx = 4'(lst[i]); d_val = 1'b1;
      @(negedge clk);
      m4[lst[i]] = 1'b1;
    end
    d_we = 1'b0;
    d_ev_in = 4'd13; @(negedge clk);
    checks++;
    if (d_ev_out !== m4[13]) begin errors++; $display("FAIL n4 eval 13: got %b, want %b", d_ev_out, m4[13]); end
    d_ev_in = 4'd4; @(negedge clk);
    checks++;
    if (d_ev_out !== m4[4]) begin errors++; $display("FAIL n4 eval 4: got %b, want %b", d_ev_out, m4[4]); end
    q.delete();
    for (int i = 0; i < 16; i++) begin
      r.idx = 4'(i); r.b = m4[i]; r.last = (i == 15);
      q.push_back(r);
    end
    d_start = 1'b1; @(negedge clk); d_start = 1'b0;
    cyc = 0;
    while (!d_done && cyc < 64) begin
      e = (q.size() > 0) ? q[0] : '0;
      checks++;
      if (q.size() == 0 || d_valid !== 1'b1 || d_oidx !== e.idx || d_bit !== e.b || d_last !== e.last) begin
        errors++;
        $display("FAIL n4 row cyc=%0d: got idx=%0d bit=%b last=%b, want idx=%0d bit=%b last=%b", cyc, d_oidx, d_bit, d_last, e.idx, e.b, e.last);
      end else begin
        void'(q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (d_done !== 1'b1 || cyc != 16 || d_ones !== 5'd7) begin
      errors++; $display("FAIL n4 sweep: done=%b cyc=%0d ones=%0d, want 1 16 7", d_done, cyc, d_ones);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int i;
    ev_in = 3'd5; mpos = 1'b0;
    start = 1'b1; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (o_idx !== 3'd3 && i < 20) begin @(negedge clk); i++; end
    checks++;
    if (o_idx !== 3'd3 || busy !== 1'b1 || ev_out !== m3[5] || ones === 4'd0) begin
      errors++; $display("FAIL pre-reset: idx=%0d busy=%b eval=%b ones=%0d, want 3 1 %b nonzero", o_idx, busy, ev_out, m3[5], ones);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || o_valid !== 1'b0 || done !== 1'b0 || ones !== 4'd0 || ev_out !== 1'b0) begin
      errors++; $display("FAIL async reset: busy=%b valid=%b done=%b ones=%0d eval=%b, want all 0", busy, o_valid, done, ones, ev_out);
    end
    m3 = '0; m4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep3(1'b0, 1'b0, 1'b0, 8, 0);
  endtask

  initial begin
    {c_clr, c_we, c_val, mpos, start, c_idx, ev_in} = '0;
    {d_clr, d_we, d_val, d_mpos, d_start, d_idx, d_ev_in} = '0;
    rdy = 1'b1; d_rdy = 1'b1;
    m3 = '0; m4 = '0;
    test_reset();
    load3(8'b1100_0110);                 // minterms {1,2,6,7}
    sweep3(1'b0, 1'b0, 1'b0, 8, 4);      // SoP
    sweep3(1'b1, 1'b0, 1'b0, 8, 4);      // PoS
    test_eval();
    load3(8'b1110_1000);                 // minterms {3,5,6,7}
    sweep3(1'b0, 1'b0, 1'b0, 8, 4);
    sweep3(1'b0, 1'b1, 1'b0, 16, 4);     // backpressure
    sweep3(1'b0, 1'b0, 1'b1, 8, 4);      // cfg_we/start during RUN ignored
    test_write_timing();
    wr3(1'b1, 1'b1, 3'd5, 1'b1);         // clear + write same cycle
    sweep3(1'b0, 1'b0, 1'b0, 8, 1);
    test_eval();
    test_n4();
    load3(8'b0010_0110);
    sweep3(1'b0, 1'b0, 1'b0, 8, 3);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
